fde_stage_sequencer: RTL and testbench

- Control FSM that runs the fetch -> decode -> execute loop of the fetching/decoding IP.
- Drives each stage through an ap_ctrl_hs-style start/done handshake.
- Counts completed instructions.
- Ends a run on halt, iteration limit, external abort or per-stage watchdog timeout.
- Sits between the top-level ap_ctrl port and the fetch, decode and execute engines. It replaces the HLS-generated loop FSM so the loop can be monitored and controlled directly.

---
 rtl/fde_seq_pkg.sv | 29 ++
 rtl/fde_stage_timer.sv | 43 ++++
 rtl/fde_stage_sequencer.sv | 150 +++++++++++++++
 tb/tb_fde_stage_sequencer.sv | 257 +++++++++++++++++++++++++
 4 files changed

// File: rtl/fde_seq_pkg.sv
// ============================================================================
// Module  : fde_seq_pkg
// Purpose : Shared types for the fetch/decode/execute stage sequencer:
//           the state encoding (also exported on the stage port), its width,
//           and a helper that identifies the states waiting on an engine.
// Rev     : 1.0  initial release
// ============================================================================
`default_nettype none

package fde_seq_pkg;

  localparam int STAGE_W = 3;

  typedef enum logic [STAGE_W-1:0] {
    ST_IDLE   = 3'd0,
    ST_FETCH  = 3'd1,
    ST_DECODE = 3'd2,
    ST_EXEC   = 3'd3,
    ST_DONE   = 3'd4
  } stage_e;

  // True in the states where an engine is running and a done is awaited.
  function automatic logic is_busy(input stage_e s);
    return (s == ST_FETCH) || (s == ST_DECODE) || (s == ST_EXEC);
  endfunction

endpackage

`default_nettype wire

// File: rtl/fde_stage_timer.sv
// ============================================================================
// Module  : fde_stage_timer
// Purpose : Per-stage watchdog. Counts cycles spent waiting on an engine and
//           flags expiry on the TIMEOUT-th waiting cycle. TIMEOUT = 0 disables.
// Ports   : clock, reset (sync, active-high)
//           i_clear   - restart count (asserted the cycle before a state entry)
//           i_enable  - count while waiting on an engine
//           o_expired - combinational, high in the last allowed waiting cycle
// Rev     : 1.0  initial release
// ============================================================================
`default_nettype none

module fde_stage_timer #(
  parameter int TIMEOUT_W = 16,
  parameter int TIMEOUT   = 1000
) (
  input  logic clock,
  input  logic reset,
  input  logic i_clear,
  input  logic i_enable,
  output logic o_expired
);

  localparam logic                 C_WD_ON = (TIMEOUT != 0);
  localparam logic [TIMEOUT_W-1:0] C_LIMIT = TIMEOUT_W'(TIMEOUT - 1);

  logic [TIMEOUT_W-1:0] r_count;

  // Count reads 0 in the first cycle of a state, so expiry at TIMEOUT-1
  // gives exactly TIMEOUT waiting cycles.
  always_ff @(posedge clock) begin
    if (reset || i_clear) begin
      r_count <= '0;
    end else if (i_enable && C_WD_ON) begin
      r_count <= r_count + 1'b1;
    end
  end

  assign o_expired = C_WD_ON && i_enable && (r_count == C_LIMIT);

endmodule

`default_nettype wire

// File: rtl/fde_stage_sequencer.sv
// ============================================================================
// Module  : fde_stage_sequencer
// Purpose : Control FSM running the fetch -> decode -> execute loop with
//           ap_ctrl_hs-style start/done handshakes per engine, an iteration
//           counter, and termination on halt, iteration limit, abort or
//           per-stage watchdog timeout.
// Ports   : clock/reset          - single clock, sync active-high reset
//           ap_start/done/ready/idle - top-level block control
//           max_iter             - iteration limit latched at start, 0 = none
//           abort                - terminate the active run
//           {fetch,decode,exec}_start/_done - engine handshakes
//           exec_halt            - with exec_done: program halted
//           iter_count           - completed executes in current/last run
//           stage                - registered state code
//           timeout_err          - sticky watchdog flag for the last run
// Rev     : 1.0  initial release
// ============================================================================
`default_nettype none

module fde_stage_sequencer
  import fde_seq_pkg::*;
#(
  parameter int ITER_W    = 32,
  parameter int TIMEOUT_W = 16,
  parameter int TIMEOUT   = 1000
) (
  input  logic               clock,
  input  logic               reset,
  input  logic               ap_start,
  output logic               ap_done,
  output logic               ap_ready,
  output logic               ap_idle,
  input  logic [ITER_W-1:0]  max_iter,
  input  logic               abort,
  output logic               fetch_start,
  input  logic               fetch_done,
  output logic               decode_start,
  input  logic               decode_done,
  output logic               exec_start,
  input  logic               exec_done,
  input  logic               exec_halt,
  output logic [ITER_W-1:0]  iter_count,
  output logic [STAGE_W-1:0] stage,
  output logic               timeout_err
);

  stage_e              r_state;
  logic                r_fetch_start;
  logic                r_decode_start;
  logic                r_exec_start;
  logic                r_ap_done;
  logic                r_ap_idle;
  logic                r_timeout_err;
  logic [ITER_W-1:0]   r_iter;
  logic [ITER_W-1:0]   r_max_iter;

  stage_e              w_next;
  logic                w_done;
  logic                w_expired;
  logic                w_wd_err;
  logic                w_exec_acc;
  logic                w_limit_hit;
  logic [ITER_W-1:0]   w_iter_inc;

  // Done of the engine owned by the current state; others are ignored.
  always_comb begin
    w_done = 1'b0;
    case (r_state)
      ST_FETCH:  w_done = fetch_done;
      ST_DECODE: w_done = decode_done;
      ST_EXEC:   w_done = exec_done;
      default:   w_done = 1'b0;
    endcase
  end

  assign w_exec_acc  = (r_state == ST_EXEC) && exec_done;
  assign w_iter_inc  = (&r_iter) ? r_iter : r_iter + 1'b1;
  assign w_limit_hit = (r_max_iter != '0) && (w_iter_inc == r_max_iter);
  // A done arriving in the expiry cycle wins over the watchdog.
  assign w_wd_err    = w_expired && !w_done;

  always_comb begin
    w_next = r_state;
    case (r_state)
      ST_IDLE:   if (ap_start) w_next = ST_FETCH;
      ST_FETCH:  if (abort || w_wd_err) w_next = ST_DONE;
                 else if (fetch_done) w_next = ST_DECODE;
      ST_DECODE: if (abort || w_wd_err) w_next = ST_DONE;
                 else if (decode_done) w_next = ST_EXEC;
      ST_EXEC:   if (abort || w_wd_err) w_next = ST_DONE;
                 else if (exec_done) w_next = (exec_halt || w_limit_hit) ? ST_DONE : ST_FETCH;
      ST_DONE:   w_next = ST_IDLE;
      default:   w_next = ST_IDLE;
    endcase
  end

  fde_stage_timer #(
    .TIMEOUT_W (TIMEOUT_W),
    .TIMEOUT   (TIMEOUT)
  ) u_timer (
    .clock     (clock),
    .reset     (reset),
    .i_clear   (w_next != r_state),
    .i_enable  (is_busy(r_state)),
    .o_expired (w_expired)
  );

  // Outputs are registered from the next state so they line up with it.
  always_ff @(posedge clock) begin
    if (reset) begin
      r_state        <= ST_IDLE;
      r_fetch_start  <= 1'b0;
      r_decode_start <= 1'b0;
      r_exec_start   <= 1'b0;
      r_ap_done      <= 1'b0;
      r_ap_idle      <= 1'b1;
      r_timeout_err  <= 1'b0;
      r_iter         <= '0;
      r_max_iter     <= '0;
    end else begin
      r_state        <= w_next;
      r_fetch_start  <= (w_next == ST_FETCH);
      r_decode_start <= (w_next == ST_DECODE);
      r_exec_start   <= (w_next == ST_EXEC);
      r_ap_done      <= (w_next == ST_DONE);
      r_ap_idle      <= (w_next == ST_IDLE);
      if ((r_state == ST_IDLE) && ap_start) begin
        r_max_iter    <= max_iter;
        r_iter        <= '0;
        r_timeout_err <= 1'b0;
      end
      // Abort in the same cycle does not cancel an accepted exec_done.
      if (w_exec_acc) r_iter <= w_iter_inc;
      if (w_wd_err)   r_timeout_err <= 1'b1;
    end
  end

  assign fetch_start  = r_fetch_start;
  assign decode_start = r_decode_start;
  assign exec_start   = r_exec_start;
  assign ap_done      = r_ap_done;
  assign ap_ready     = r_ap_done;
  assign ap_idle      = r_ap_idle;
  assign iter_count   = r_iter;
  assign stage        = r_state;
  assign timeout_err  = r_timeout_err;

endmodule

`default_nettype wire

// File: tb/tb_fde_stage_sequencer.sv
// ============================================================================
// Module  : tb_fde_stage_sequencer
// Purpose : Self-checking bench for fde_stage_sequencer. Each run is planned
//           up front (per-handshake engine latency, limit, halt, abort); a
//           run-level model predicts final count, error flag and the cycle of
//           ap_done, which a separate monitor compares when ap_done pulses.
// Rev     : 1.0  initial release
// ============================================================================
`default_nettype none

module tb_fde_stage_sequencer;

  localparam int ITER_W    = 3;
  localparam int TIMEOUT_W = 8;
  localparam int TIMEOUT   = 16;
  localparam int NEVER     = 1000;
  localparam int NPLAN     = 40;
  localparam int CAP       = (1 << ITER_W) - 1;

  logic              clock = 1'b0;
  logic              reset = 1'b1;
  logic              ap_start = 1'b0;
  logic              ap_done, ap_ready, ap_idle;
  logic [ITER_W-1:0] max_iter = '0;
  logic              abort = 1'b0;
  logic              fetch_start, decode_start, exec_start;
  logic              fetch_done = 1'b0, decode_done = 1'b0, exec_done = 1'b0;
  logic              exec_halt = 1'b0;
  logic [ITER_W-1:0] iter_count;
  logic [2:0]        stage;
  logic              timeout_err;

  fde_stage_sequencer #(
    .ITER_W(ITER_W), .TIMEOUT_W(TIMEOUT_W), .TIMEOUT(TIMEOUT)
  ) dut (
    .clock(clock), .reset(reset), .ap_start(ap_start), .ap_done(ap_done),
    .ap_ready(ap_ready), .ap_idle(ap_idle), .max_iter(max_iter), .abort(abort),
    .fetch_start(fetch_start), .fetch_done(fetch_done),
    .decode_start(decode_start), .decode_done(decode_done),
    .exec_start(exec_start), .exec_done(exec_done), .exec_halt(exec_halt),
    .iter_count(iter_count), .stage(stage), .timeout_err(timeout_err)
  );

  always #5 clock = ~clock;

  int cyc = 0;
  always @(posedge clock) cyc <= cyc + 1;

  int vectors = 0;
  int miscompares = 0;

  typedef struct {
    int iter;
    int err;
    int done_cyc;
  } exp_t;
  exp_t sb_q[$];

  // Run plan
  int lat [NPLAN];
  int max_i, halt_it, abort_h, abort_c;

  task automatic chk(input string nm, input longint act, input longint req);
    vectors++;
    if (act != req) begin
      miscompares++;
      $display("FAIL %s: got %0d, expected %0d (t=%0t)", nm, act, req, $time);
    end
  endtask

  // Run-level model: walk the planned handshakes; each stage ends at the
  // earliest of engine done, planned abort and watchdog expiry.
  function automatic exp_t model_run(input int start_cyc);
    exp_t r;
    int   iter = 0, total = 0, h = 0, e, l;
    bit   fin = 0;
    r.err = 0;
    while (!fin && h < NPLAN) begin
      l = lat[h];
      e = l;
      if (h == abort_h && abort_c < e) e = abort_c;
      if (TIMEOUT - 1 < e) e = TIMEOUT - 1;
      total += e + 1;
      if (l == e) begin
        if (h % 3 == 2) begin
          if (iter < CAP) iter++;
          if ((h / 3 + 1) == halt_it || (max_i != 0 && iter == max_i)) fin = 1;
        end
      end else if (e == TIMEOUT - 1) begin
        r.err = 1;
        fin   = 1;
      end
      if (h == abort_h && abort_c == e) fin = 1;
      h++;
    end
    r.iter     = iter;
    r.done_cyc = start_cyc + 1 + total;
    return r;
  endfunction

  task automatic set_plan(input int l, input int mx, input int hl, input int ah, input int ac);
    for (int i = 0; i < NPLAN; i++) lat[i] = l;
    max_i = mx; halt_it = hl; abort_h = ah; abort_c = ac;
  endtask

  task automatic rand_plan();
    int r;
    for (int i = 0; i < NPLAN; i++) begin
      r = $urandom_range(0, 39);
      if (r < 33)      lat[i] = r % 4;
      else if (r < 36) lat[i] = TIMEOUT - 1;
      else if (r < 38) lat[i] = TIMEOUT - 2;
      else if (r < 39) lat[i] = 6;
      else             lat[i] = NEVER;
    end
    max_i   = $urandom_range(0, 7);
    halt_it = ($urandom_range(0, 2) == 0) ? 0 : $urandom_range(1, 12);
    if (max_i == 0 && halt_it == 0) halt_it = $urandom_range(1, 12);
    if ($urandom_range(0, 2) == 0) begin
      abort_h = $urandom_range(0, 35);
      abort_c = $urandom_range(0, 4);
    end else begin
      abort_h = -1;
      abort_c = 0;
    end
  endtask

  // Starts one run from IDLE and plays the engines according to the plan.
  task automatic run_one();
    exp_t ex;
    int   h = -1, cnt = 0, prev = 0, s, hl, guard = 0;
    @(negedge clock);
    max_iter = ITER_W'(max_i);
    ap_start = 1'b1;
    ex = model_run(cyc);
    sb_q.push_back(ex);
    @(negedge clock);
    ap_start = 1'b0;
    chk("err_cleared_at_start", timeout_err, 0);
    forever begin
      s = int'(stage);
      if (s == 0 || s == 4 || guard > 3000) break;
      if (s != prev) begin h++; cnt = 0; end else cnt++;
      prev = s;
      guard++;
      hl = (h >= 0 && h < NPLAN) ? lat[h] : NEVER;
      fetch_done  = (s == 1) ? (cnt == hl) : 1'($urandom_range(0, 1));
      decode_done = (s == 2) ? (cnt == hl) : 1'($urandom_range(0, 1));
      exec_done   = (s == 3) ? (cnt == hl) : 1'($urandom_range(0, 1));
      exec_halt   = (s == 3 && cnt == hl) ? ((h / 3 + 1) == halt_it)
                                          : 1'($urandom_range(0, 1));
      abort       = (h == abort_h && cnt == abort_c);
      @(negedge clock);
    end
    chk("run_reaches_done_state", s, 4);
    fetch_done = 0; decode_done = 0; exec_done = 0; exec_halt = 0; abort = 0;
    @(negedge clock);
    chk("idle_after_done_stage", stage, 0);
    chk("idle_after_done_ap_idle", ap_idle, 1);
    chk("iter_hold", iter_count, ex.iter);
    chk("err_hold", timeout_err, ex.err);
    // Stray dones and abort while idle must not start anything.
    for (int i = 0; i < 2; i++) begin
      abort       = 1'($urandom_range(0, 1));
      fetch_done  = 1'($urandom_range(0, 1));
      decode_done = 1'($urandom_range(0, 1));
      exec_done   = 1'($urandom_range(0, 1));
      @(negedge clock);
      chk("idle_ignores_inputs", stage, 0);
    end
    abort = 0; fetch_done = 0; decode_done = 0; exec_done = 0;
  endtask

  // Monitor: compares scoreboard entries at each ap_done, plus invariants.
  initial begin
    exp_t ex;
    forever begin
      @(negedge clock);
      chk("starts_onehot", ($countones({fetch_start, decode_start, exec_start}) <= 1), 1);
      chk("ready_eq_done", ap_ready, ap_done);
      if (ap_done) begin
        if (sb_q.size() == 0) begin
          chk("unexpected_ap_done", 1, 0);
        end else begin
          ex = sb_q.pop_front();
          chk("iter_count", iter_count, ex.iter);
          chk("timeout_err", timeout_err, ex.err);
          chk("ap_done_cycle", cyc, ex.done_cyc);
          chk("done_not_idle", ap_idle, 0);
        end
      end
    end
  end

  initial begin
    int g;
    repeat (3) @(negedge clock);
    chk("rst_stage", stage, 0);
    chk("rst_idle", ap_idle, 1);
    chk("rst_starts", {fetch_start, decode_start, exec_start}, 0);
    chk("rst_done", ap_done, 0);
    chk("rst_iter", iter_count, 0);
    chk("rst_err", timeout_err, 0);
    reset = 1'b0;

    // Basic loop, halt, zero latency, timeout, abort-with-done, saturation.
    set_plan(2, 3, 0, -1, 0);  run_one();
    set_plan(1, 0, 5, -1, 0);  run_one();
    set_plan(0, 2, 0, -1, 0);  run_one();
    set_plan(2, 0, 9, -1, 0);  lat[1] = NEVER; run_one();
    set_plan(2, 0, 9, -1, 0);  run_one();
    set_plan(2, 0, 9, 5, 2);   run_one();
    set_plan(0, 0, 10, -1, 0); run_one();
    set_plan(1, 0, 9, 4, 0);   lat[4] = TIMEOUT - 1; run_one();
    set_plan(1, 0, 9, -1, 0);  lat[2] = TIMEOUT - 1; run_one();

    for (int n = 0; n < 30; n++) begin
      rand_plan();
      run_one();
    end

    // Reset mid-run in DECODE after one completed iteration.
    @(negedge clock);
    max_iter = '0; ap_start = 1'b1;
    fetch_done = 1; decode_done = 1; exec_done = 1; exec_halt = 0;
    g = 0;
    @(negedge clock);
    ap_start = 1'b0;
    while (!(stage == 3'd2 && iter_count != '0) && g < 20) begin
      @(negedge clock);
      g++;
    end
    chk("reach_decode_iter2", g < 20, 1);
    decode_done = 0; fetch_done = 0; exec_done = 0;
    reset = 1'b1;
    @(negedge clock);
    reset = 1'b0;
    chk("midrst_starts", {fetch_start, decode_start, exec_start}, 0);
    chk("midrst_stage", stage, 0);
    chk("midrst_idle", ap_idle, 1);
    chk("midrst_iter", iter_count, 0);
    decode_done = 1;
    repeat (3) begin
      @(negedge clock);
      chk("midrst_stray_decode_done", {decode_start, stage}, 0);
    end
    decode_done = 0;

    repeat (3) @(negedge clock);
    chk("scoreboard_empty", sb_q.size(), 0);
    $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
    $finish;
  end

endmodule

`default_nettype wire
